// File: rtl/pattern_response_checker_if.sv
// Response transfer channel between the capture logic (master) and the checker (slave).
// valid/ready: a word moves on a rising edge where resp_valid and resp_ready are both high.
interface pattern_response_checker_if #(
  parameter int W = 4
);
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic [W-1:0] exp_data;
  logic [W-1:0] mask;

  modport master (
    output resp_valid,
    output resp_data,
    output exp_data,
    output mask,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp_data,
    input  exp_data,
    input  mask,
    output resp_ready
  );
endinterface

// File: rtl/pattern_response_checker.sv
// Compares captured responses with expected words under a don't-care mask,
// counts mismatches, records the first failing index and compacts responses in a MISR.
module pattern_response_checker #(
  parameter int          W     = 4,
  parameter int          SIG_W = 16,
  parameter int          CNT_W = 16,
  parameter logic [31:0] POLY  = 32'h0000_1021,
  parameter logic [31:0] SEED  = 32'h0000_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_patterns,
  pattern_response_checker_if.slave rsp,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          fail_count,
  output logic [CNT_W-1:0]          first_fail_idx,
  output logic [SIG_W-1:0]          signature,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [SIG_W-1:0] POLY_L   = POLY[SIG_W-1:0];
  localparam logic [SIG_W-1:0] SEED_L   = SEED[SIG_W-1:0];
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state;
  logic [CNT_W-1:0] num_l;
  logic [CNT_W-1:0] idx;

  logic [W-1:0]     diff;
  logic             mismatch;
  logic             xfer;
  logic [CNT_W-1:0] idx_next;
  logic [SIG_W-1:0] m_ext;
  logic [SIG_W-1:0] misr_next;

  assign diff     = (rsp.resp_data ^ rsp.exp_data) & ~rsp.mask;
  assign mismatch = |diff;
  assign xfer     = rsp.resp_valid & rsp.resp_ready;
  assign idx_next = idx + 1'b1;

  // Masked-off bits are zeroed before entering the MISR so don't-cares cannot perturb it.
  always_comb begin
    m_ext          = '0;
    m_ext[W-1:0]   = rsp.resp_data & ~rsp.mask;
    misr_next      = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY_L : '0)
                   ^ m_ext;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      num_l          <= '0;
      idx            <= '0;
      rsp.resp_ready <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= ALL_ONES;
      signature      <= SEED_L;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx            <= '0;
            fail_count     <= '0;
            first_fail_idx <= ALL_ONES;
            signature      <= SEED_L;
            if (num_patterns != '0) begin
              num_l          <= num_patterns;
              pass           <= 1'b0;
              busy           <= 1'b1;
              rsp.resp_ready <= 1'b1;
              state          <= RUN;
            end else begin
              // An empty run completes immediately and trivially passes.
              pass <= 1'b1;
              done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            if (mismatch) begin
              if (fail_count != ALL_ONES) begin
                fail_count <= fail_count + 1'b1;
              end
              if (first_fail_idx == ALL_ONES) begin
                first_fail_idx <= idx;
              end
            end
            signature <= misr_next;
            idx       <= idx_next;
            if (idx_next == num_l) begin
              rsp.resp_ready <= 1'b0;
              state          <= FLUSH;
            end
          end
        end

        FLUSH: begin
          pass  <= (fail_count == '0);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          rsp.resp_ready <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_response_checker.sv
// Bench for pattern_response_checker: table of directed runs, hand sequences for
// empty run and mid-run reset, then randomized runs against a behavioural model.
module tb_pattern_response_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_patterns;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] fail_count;
  logic [15:0] first_fail_idx;
  logic [15:0] signature;
  logic [1:0]  dbg_state;

  pattern_response_checker_if #(.W(4)) rif ();

  pattern_response_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_patterns   (num_patterns),
    .rsp            (rif),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .signature      (signature),
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [7:0][3:0] r;
    logic [7:0][3:0] e;
    logic [7:0][3:0] m;
    int              gap;
    bit              mid_start;
    int              xfail;
    int              xfirst;
    bit              xpass;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t        tbl [7];
  logic [15:0] dut_sig [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: fold every accepted word into the signature, masked bits forced to zero.
  function automatic logic [15:0] model_sig(input vec_t v);
    logic [15:0] s;
    logic [15:0] mv;
    s = 16'hFFFF;
    for (int i = 0; i < v.n; i++) begin
      mv = {12'h000, v.r[i] & ~v.m[i]};
      s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ mv;
    end
    return s;
  endfunction

  function automatic int model_fails(input vec_t v);
    int c;
    c = 0;
    for (int i = 0; i < v.n; i++)
      if (((v.r[i] ^ v.e[i]) & ~v.m[i]) != 4'h0) c++;
    return c;
  endfunction

  function automatic int model_first(input vec_t v);
    for (int i = 0; i < v.n; i++)
      if (((v.r[i] ^ v.e[i]) & ~v.m[i]) != 4'h0) return i;
    return 16'hFFFF;
  endfunction

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send(input logic [3:0] r, input logic [3:0] e, input logic [3:0] m, input int gap);
    int budget;
    while ($urandom_range(0, 99) < gap) begin
      rif.resp_valid = 1'b0;
      @(negedge clk);
    end
    rif.resp_valid = 1'b1;
    rif.resp_data  = r;
    rif.exp_data   = e;
    rif.mask       = m;
    budget = 50;
    while (!rif.resp_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!rif.resp_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: resp_ready stayed 0, expected 1");
    end
    @(negedge clk);
    rif.resp_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start        = 1'b1;
    num_patterns = n;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag, output logic [15:0] sig_out);
    pulse_start(v.n[15:0]);
    chk({tag, "_busy_start"}, busy, 1);
    for (int i = 0; i < v.n; i++) begin
      if (v.mid_start && i == 3) pulse_start(16'd2);
      send(v.r[i], v.e[i], v.m[i], v.gap);
    end
    chk({tag, "_flush_ready"}, rif.resp_ready, 0);
    chk({tag, "_flush_done"}, done, 0);
    chk({tag, "_flush_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_fail_count"}, fail_count, v.xfail);
    chk({tag, "_first_fail"}, first_fail_idx, v.xfirst);
    chk({tag, "_pass"}, pass, v.xpass);
    chk({tag, "_signature"}, signature, model_sig(v));
    sig_out = signature;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_pass_hold"}, pass, v.xpass);
  endtask

  initial begin
    logic [15:0] s;
    vec_t        v;
    bit          done_seen;

    rst = 1'b1; start = 1'b0; num_patterns = '0;
    rif.resp_valid = 1'b0; rif.resp_data = '0; rif.exp_data = '0; rif.mask = '0;

    tbl[0] = '{4, 32'h0000_FA53, 32'h0000_FA53, 32'h0, 0, 0, 0, 16'hFFFF, 1};
    tbl[1] = '{4, 32'h0000_FB53, 32'h0000_FA53, 32'h0, 0, 0, 1, 2, 0};
    tbl[2] = '{4, 32'h0000_FB53, 32'h0000_FA53, 32'h0000_0100, 0, 0, 0, 16'hFFFF, 1};
    tbl[3] = '{8, 32'h8C71_FB53, 32'h8C71_FA53, 32'h0, 0, 0, 1, 2, 0};
    tbl[4] = '{8, 32'h8C71_FB53, 32'h8C71_FA53, 32'h0, 50, 1, 1, 2, 0};
    tbl[5] = '{5, 32'h0009_0630, 32'h0, 32'h000F_0000, 20, 0, 2, 1, 0};
    tbl[6] = '{1, 32'h5, 32'h4, 32'h0, 0, 0, 1, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_ready", rif.resp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_first_fail", first_fail_idx, 16'hFFFF);
    chk("rst_signature", signature, 16'hFFFF);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      run_vec(tbl[k], $sformatf("vec%0d", k), s);
      dut_sig[k] = s;
    end
    chk("mask_sig_equals_clean", dut_sig[2], dut_sig[0]);
    chk("stall_sig_equals_b2b", dut_sig[4], dut_sig[3]);

    // Empty run: done follows start directly, nothing accepted even with valid high.
    rif.resp_valid = 1'b1;
    pulse_start(16'd0);
    chk("empty_done", done, 1);
    chk("empty_pass", pass, 1);
    chk("empty_signature", signature, 16'hFFFF);
    chk("empty_fail_count", fail_count, 0);
    chk("empty_first_fail", first_fail_idx, 16'hFFFF);
    chk("empty_ready", rif.resp_ready, 0);
    @(negedge clk);
    chk("empty_done_pulse", done, 0);
    chk("empty_busy", busy, 0);
    rif.resp_valid = 1'b0;

    // Reset after two failing transfers aborts the run without a done pulse.
    pulse_start(16'd4);
    send(4'h1, 4'h0, 4'h0, 0);
    send(4'h2, 4'h0, 4'h0, 0);
    chk("pre_abort_fail_count", fail_count, 2);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", rif.resp_ready, 0);
    chk("abort_signature", signature, 16'hFFFF);
    chk("abort_fail_count", fail_count, 0);
    chk("abort_first_fail", first_fail_idx, 16'hFFFF);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 0);
    run_vec(tbl[0], "cold", s);

    // Random runs against the model.
    for (int k = 0; k < 20; k++) begin
      v.n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) begin
        v.e[i] = 4'($urandom);
        v.r[i] = ($urandom_range(0, 1) == 0) ? v.e[i] : 4'($urandom);
        v.m[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      end
      v.gap       = $urandom_range(0, 60);
      v.mid_start = ($urandom_range(0, 1) == 1) && (v.n > 3);
      v.xfail     = model_fails(v);
      v.xfirst    = model_first(v);
      v.xpass     = (v.xfail == 0);
      run_vec(v, $sformatf("rnd%0d", k), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_response_checker.md
Name: pattern_response_checker

Overview:
Response-side counterpart of the fault-simulation pattern driver. It accepts captured circuit outputs, one per applied pattern, and compares each against an expected response under a don't-care mask. It counts mismatches, records the index of the first failing pattern, and compacts all masked responses into a MISR signature. It sits between the device-under-test output capture and the fault report logic.

Parameters:
W, 4, width of one captured response / expected response / mask word
SIG_W, 16, MISR signature width (must be >= W)
CNT_W, 16, width of pattern count, index and mismatch counters
POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used)
SEED, 16'hFFFF, MISR reset/start value (low SIG_W bits used)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a run of num_patterns responses
num_patterns  input  CNT_W  responses expected in the run; sampled on start
resp_valid  input  1  resp_data/exp_data/mask valid this cycle
resp_ready  output  1  checker can accept a response
resp_data  input  W  captured DUT output word
exp_data  input  W  expected (good-machine) output word
mask  input  W  1 = don't-care bit, excluded from compare and MISR
busy  output  1  run in progress
done  output  1  one-cycle pulse when the run completes
pass  output  1  high when last completed run had zero mismatches
fail_count  output  CNT_W  mismatching responses in current/last run
first_fail_idx  output  CNT_W  0-based index of first mismatch; all-ones if none
signature  output  SIG_W  MISR state

Behaviour:
- Reset (async, immediate): state IDLE; resp_ready=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=all-ones, signature=SEED, internal index=0.
- States: IDLE, RUN, FLUSH.
- IDLE: resp_ready=0. On start with num_patterns!=0: latch num_patterns, index=0, fail_count=0, first_fail_idx=all-ones, signature=SEED, pass=0, go to RUN. On start with num_patterns==0: stay IDLE, pulse done next cycle, pass=1, signature=SEED, counters cleared.
- RUN: busy=1, resp_ready=1. A transfer is resp_valid & resp_ready. Per transfer, registered on that edge:
  - diff = (resp_data ^ exp_data) & ~mask; mismatch = |diff.
  - if mismatch: fail_count saturates at all-ones, else +1; if first_fail_idx is all-ones, it takes index.
  - MISR: m = zero-extend(resp_data & ~mask) to SIG_W; signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ m.
  - index+1. If the new count equals the latched num_patterns, go to FLUSH.
  - No transfer -> no state change (stalls are allowed indefinitely).
- FLUSH: one cycle; resp_ready=0, busy=1; pass <= (fail_count==0); done pulses the following cycle as the block returns to IDLE. Latency from last transfer edge to done high: 2 cycles.
- start while busy: ignored.
- resp_valid in IDLE/FLUSH: not accepted, no effect.
- Outputs hold after done until the next start or reset.
- Reset asserted mid-run aborts: all outputs take their reset values and done is not pulsed.
- Masked bits never cause a mismatch and never enter the MISR.

Test Plan:
- W=4, num_patterns=4, responses 0x3,0x5,0xA,0xF equal to expected, mask=0 -> fail_count=0, first_fail_idx=0xFFFF, pass=1, done 2 cycles after 4th transfer, signature matches reference-model MISR from 0xFFFF.
- Same run, response #2 = 0xB, expected 0xA -> fail_count=1, first_fail_idx=2, pass=0.
- Response 0xB vs expected 0xA with mask=0x1 -> no mismatch, pass=1; signature equals the run with response 0xA.
- resp_valid toggled randomly (~50% duty), 8 patterns -> identical counters and signature to the back-to-back run; start pulsed mid-run is ignored.
- num_patterns=0 with start -> done one cycle later, pass=1, signature=0xFFFF, no transfers accepted.
- rst asserted after 2 of 4 transfers -> resp_ready=0, signature=0xFFFF, fail_count=0, no done; a new run after reset behaves as from cold start.
